stage_ex: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. Consumes the decoded ID/EX bundle and resolves operand forwarding from MEM and WB. Computes the ALU result, evaluates branches and jumps, and drives the PC redirect back to IF/ID. Owns the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/rv_pkg.sv | 61 ++++++
 rtl/stage_ex_if.sv | 60 ++++++
 rtl/stage_ex_alu.sv | 42 ++++
 rtl/stage_ex.sv | 162 ++++++++++++++++
 tb/tb_stage_ex.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, branch condition codes,
// operand/writeback select encodings and forwarding source selects.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    // ALU operation, encoded as {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_NOP  = 4'b1111
    } alu_op_e;

    // Conditional branch funct3 codes
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

    // Operand and writeback source selects
    localparam logic OP1FromRS1 = 1'b0;
    localparam logic OP1FromPC  = 1'b1;
    localparam logic OP2FromRS2 = 1'b0;
    localparam logic OP2FromIMM = 1'b1;
    localparam logic WbRd       = 1'b0;
    localparam logic WbPC       = 1'b1;

    // Where an EX source operand comes from
    typedef enum logic [1:0] {
        EXFromID    = 2'd0,
        EXFwFromMEM = 2'd1,
        EXFwFromWB  = 2'd2
    } fwd_sel_e;

    // Pick the forwarding source for one register operand. x0 never
    // forwards; the younger MEM result wins over WB.
    function automatic fwd_sel_e fwd_select(logic [4:0] src_idx,
                                            logic [4:0] mem_idx,
                                            logic [4:0] wb_idx);
        fwd_sel_e sel;
        sel = EXFromID;
        if (src_idx != 5'd0 && src_idx == mem_idx)
            sel = EXFwFromMEM;
        else if (src_idx != 5'd0 && src_idx == wb_idx)
            sel = EXFwFromWB;
        return sel;
    endfunction

endpackage

// File: rtl/stage_ex_if.sv
// ID/EX bundle, forwarding inputs, redirect and EX/MEM outputs of the
// execute stage. 'slave' is the stage side, 'master' the surrounding pipe.
interface stage_ex_if #(parameter int XLEN = 32);

    // pipeline control
    logic            stall;
    logic            clear;
    // decoded ID/EX bundle
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            br_en;
    logic            is_jalr;
    logic            op1_ctrl;
    logic            op2_ctrl;
    logic            wb_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic            mem_rd;
    logic            mem_wr;
    // forwarding
    logic [4:0]      rd_idx_fromMEM;
    logic [4:0]      rd_idx_fromWB;
    logic [XLEN-1:0] alu_out_fromMEM;
    logic [XLEN-1:0] wb_data_fromWB;
    // redirect
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    // EX/MEM register
    logic [XLEN-1:0] alu_out_toMEM;
    logic [XLEN-1:0] rs2_toMEM;
    logic [4:0]      rd_idx_toMEM;
    logic [2:0]      funct3_toMEM;
    logic            mem_rd_toMEM;
    logic            mem_wr_toMEM;

    modport slave (
        input  stall, clear, alu_op, funct3, br_en, is_jalr, op1_ctrl,
               op2_ctrl, wb_sel, imm, rs1, rs2, pc, pc4, rs1_idx, rs2_idx,
               rd_idx, mem_rd, mem_wr, rd_idx_fromMEM, rd_idx_fromWB,
               alu_out_fromMEM, wb_data_fromWB,
        output br_taken, br_target, alu_out_toMEM, rs2_toMEM, rd_idx_toMEM,
               funct3_toMEM, mem_rd_toMEM, mem_wr_toMEM
    );

    modport master (
        output stall, clear, alu_op, funct3, br_en, is_jalr, op1_ctrl,
               op2_ctrl, wb_sel, imm, rs1, rs2, pc, pc4, rs1_idx, rs2_idx,
               rd_idx, mem_rd, mem_wr, rd_idx_fromMEM, rd_idx_fromWB,
               alu_out_fromMEM, wb_data_fromWB,
        input  br_taken, br_target, alu_out_toMEM, rs2_toMEM, rd_idx_toMEM,
               funct3_toMEM, mem_rd_toMEM, mem_wr_toMEM
    );

endinterface

// File: rtl/stage_ex_alu.sv
// Combinational RV32I ALU. With an immediate second operand the funct7[5]
// bit is part of the immediate, so 1000 means ADDI, except for SRAI where
// that bit genuinely selects the arithmetic shift.
module alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [3:0]      alu_op_i,
    input  logic            op2_is_imm_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = op2_i[4:0];
    assign lt_s  = $signed(op1_i) < $signed(op2_i);
    assign lt_u  = op1_i < op2_i;

    // operation decode; unknown codes and NOP produce zero
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = op1_i + op2_i;
            ALU_SUB:  result_o = op2_is_imm_i ? (op1_i + op2_i) : (op1_i - op2_i);
            ALU_SLL:  result_o = op1_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_SRL:  result_o = op1_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(op1_i) >>> shamt);
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU, branch resolution with PC
// redirect, and the EX/MEM pipeline register.
// Build option: define STAGE_EX_FWD_EN to enable MEM/WB forwarding; without
// it the operands are always the ID/EX values and the forwarding ports are
// ignored (the hazard unit then stalls on every RAW dependency).
module stage_ex
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    stage_ex_if.slave  bus
);

    fwd_sel_e        rs1_sel;
    fwd_sel_e        rs2_sel;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] sum;
    logic            cond;
    logic            jump;
    logic            cond_br;

    logic [XLEN-1:0] alu_out_d, alu_out_q;
    logic [XLEN-1:0] rs2_d,     rs2_q;
    logic [4:0]      rd_idx_d,  rd_idx_q;
    logic [2:0]      funct3_d,  funct3_q;
    logic            mem_rd_d,  mem_rd_q;
    logic            mem_wr_d,  mem_wr_q;

`ifdef STAGE_EX_FWD_EN
    // forwarding source select per operand
    always_comb begin
        rs1_sel = fwd_select(bus.rs1_idx, bus.rd_idx_fromMEM, bus.rd_idx_fromWB);
        rs2_sel = fwd_select(bus.rs2_idx, bus.rd_idx_fromMEM, bus.rd_idx_fromWB);
    end
`else
    // forwarding disabled: operands always come from ID/EX
    always_comb begin
        rs1_sel = EXFromID;
        rs2_sel = EXFromID;
    end

    // forwarding ports are kept on the interface but have no function here
    logic unused_fwd;
    assign unused_fwd = ^{bus.rs1_idx, bus.rs2_idx, bus.rd_idx_fromMEM,
                          bus.rd_idx_fromWB, bus.alu_out_fromMEM,
                          bus.wb_data_fromWB};
`endif

    // forwarding muxes
    always_comb begin
        fwd_rs1 = bus.rs1;
        fwd_rs2 = bus.rs2;
        case (rs1_sel)
            EXFwFromMEM: fwd_rs1 = bus.alu_out_fromMEM;
            EXFwFromWB:  fwd_rs1 = bus.wb_data_fromWB;
            default:     fwd_rs1 = bus.rs1;
        endcase
        case (rs2_sel)
            EXFwFromMEM: fwd_rs2 = bus.alu_out_fromMEM;
            EXFwFromWB:  fwd_rs2 = bus.wb_data_fromWB;
            default:     fwd_rs2 = bus.rs2;
        endcase
    end

    assign op1 = (bus.op1_ctrl == OP1FromPC)  ? bus.pc  : fwd_rs1;
    assign op2 = (bus.op2_ctrl == OP2FromIMM) ? bus.imm : fwd_rs2;

    alu #(.XLEN(XLEN)) u_alu (
        .op1_i        (op1),
        .op2_i        (op2),
        .alu_op_i     (bus.alu_op),
        .op2_is_imm_i (bus.op2_ctrl == OP2FromIMM),
        .result_o     (alu_result)
    );

    // Target adder is independent of alu_op so a branch target is always
    // op1+op2 (pc+imm, or rs1+imm for JALR).
    assign sum = op1 + op2;

    // branch comparator on the forwarded register values
    always_comb begin
        cond = 1'b0;
        case (bus.funct3)
            BR_BEQ:  cond = (fwd_rs1 == fwd_rs2);
            BR_BNE:  cond = (fwd_rs1 != fwd_rs2);
            BR_BLT:  cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            BR_BGE:  cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_BLTU: cond = (fwd_rs1 <  fwd_rs2);
            BR_BGEU: cond = (fwd_rs1 >= fwd_rs2);
            default: cond = 1'b0;
        endcase
    end

    // JAL and JALR are the control transfers that write a link value, so a
    // link writeback marks an unconditional jump.
    assign jump    = bus.is_jalr | (bus.wb_sel == WbPC);
    assign cond_br = bus.br_en & ~jump;

    assign bus.br_taken  = bus.br_en & (jump | cond) & ~bus.stall & ~rst;
    assign bus.br_target = rst ? '0 : {sum[XLEN-1:1], sum[0] & ~bus.is_jalr};

    // EX/MEM next state: stall holds (also over clear), clear loads a bubble
    always_comb begin
        alu_out_d = alu_out_q;
        rs2_d     = rs2_q;
        rd_idx_d  = rd_idx_q;
        funct3_d  = funct3_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        if (!bus.stall) begin
            if (bus.clear) begin
                alu_out_d = '0;
                rs2_d     = '0;
                rd_idx_d  = 5'd0;
                funct3_d  = 3'd0;
                mem_rd_d  = 1'b0;
                mem_wr_d  = 1'b0;
            end else begin
                alu_out_d = (bus.wb_sel == WbPC) ? bus.pc4 : alu_result;
                rs2_d     = fwd_rs2;
                funct3_d  = bus.funct3;
                // a conditional branch leaves a write-free entry behind
                rd_idx_d  = cond_br ? 5'd0 : bus.rd_idx;
                mem_rd_d  = cond_br ? 1'b0 : bus.mem_rd;
                mem_wr_d  = cond_br ? 1'b0 : bus.mem_wr;
            end
        end
    end

    // EX/MEM register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            rs2_q     <= '0;
            rd_idx_q  <= 5'd0;
            funct3_q  <= 3'd0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            rs2_q     <= rs2_d;
            rd_idx_q  <= rd_idx_d;
            funct3_q  <= funct3_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
        end
    end

    assign bus.alu_out_toMEM = alu_out_q;
    assign bus.rs2_toMEM     = rs2_q;
    assign bus.rd_idx_toMEM  = rd_idx_q;
    assign bus.funct3_toMEM  = funct3_q;
    assign bus.mem_rd_toMEM  = mem_rd_q;
    assign bus.mem_wr_toMEM  = mem_wr_q;

endmodule

// File: tb/tb_stage_ex.sv
// Bench for stage_ex: directed vector table, stall/clear/reset sequences,
// then random traffic against a behavioural reference model.
module tb_stage_ex;
    import rv_pkg::*;

    localparam int XLEN = 32;
`ifdef STAGE_EX_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_ex_if #(.XLEN(XLEN)) bus ();
    stage_ex #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        br_en, is_jalr, op1_ctrl, op2_ctrl, wb_sel;
        logic [31:0] imm, rs1, rs2, pc, pc4;
        logic [4:0]  rs1_idx, rs2_idx, rd_idx;
        logic        mem_rd, mem_wr;
        logic [4:0]  mem_idx, wb_idx;
        logic [31:0] mem_data, wb_data;
    } in_t;

    typedef struct {
        logic        taken;
        logic [31:0] target, alu, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mrd, mwr;
    } res_t;

    typedef struct {
        string       name;
        in_t         in;
        logic        taken;
        logic [31:0] target, alu, rs2;
        logic [4:0]  rd;
        logic        mrd;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // model's view of the EX/MEM register
    res_t m_reg;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] fwd_ref(logic [4:0] idx, logic [31:0] idv, in_t v);
        if (FWD_ON && idx != 0 && idx == v.mem_idx) return v.mem_data;
        if (FWD_ON && idx != 0 && idx == v.wb_idx)  return v.wb_data;
        return idv;
    endfunction

    // reference: what the stage should present this cycle and capture next
    function automatic res_t model(in_t v, bit r, bit s);
        res_t o;
        logic [31:0] r1, r2, a, b, alu, t;
        int sa;
        int sh;
        bit cond, jump;
        r1 = fwd_ref(v.rs1_idx, v.rs1, v);
        r2 = fwd_ref(v.rs2_idx, v.rs2, v);
        a  = v.op1_ctrl ? v.pc  : r1;
        b  = v.op2_ctrl ? v.imm : r2;
        sh = int'(b % 32);
        sa = a;
        case (v.alu_op)
            4'h0: alu = a + b;
            4'h8: alu = v.op2_ctrl ? a + b : a - b;
            4'h1: alu = a << sh;
            4'h2: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: alu = (a < b) ? 32'd1 : 32'd0;
            4'h4: alu = a ^ b;
            4'h5: alu = a >> sh;
            4'hD: alu = sa >>> sh;
            4'h6: alu = a | b;
            4'h7: alu = a & b;
            default: alu = 32'd0;
        endcase
        case (v.funct3)
            3'd0: cond = (r1 == r2);
            3'd1: cond = (r1 != r2);
            3'd4: cond = $signed(r1) <  $signed(r2);
            3'd5: cond = $signed(r1) >= $signed(r2);
            3'd6: cond = r1 <  r2;
            3'd7: cond = r1 >= r2;
            default: cond = 1'b0;
        endcase
        jump = v.is_jalr || v.wb_sel;
        o.taken = v.br_en && (jump || cond) && !s && !r;
        t = a + b;
        if (v.is_jalr) t = t & ~32'd1;
        o.target = r ? 32'd0 : t;
        o.alu = v.wb_sel ? v.pc4 : alu;
        o.rs2 = r2;
        o.f3  = v.funct3;
        o.rd  = (v.br_en && !jump) ? 5'd0 : v.rd_idx;
        o.mrd = (v.br_en && !jump) ? 1'b0 : v.mem_rd;
        o.mwr = (v.br_en && !jump) ? 1'b0 : v.mem_wr;
        return o;
    endfunction

    task automatic apply(in_t v);
        bus.alu_op = v.alu_op;   bus.funct3 = v.funct3;
        bus.br_en = v.br_en;     bus.is_jalr = v.is_jalr;
        bus.op1_ctrl = v.op1_ctrl; bus.op2_ctrl = v.op2_ctrl;
        bus.wb_sel = v.wb_sel;   bus.imm = v.imm;
        bus.rs1 = v.rs1;         bus.rs2 = v.rs2;
        bus.pc = v.pc;           bus.pc4 = v.pc4;
        bus.rs1_idx = v.rs1_idx; bus.rs2_idx = v.rs2_idx;
        bus.rd_idx = v.rd_idx;   bus.mem_rd = v.mem_rd;
        bus.mem_wr = v.mem_wr;
        bus.rd_idx_fromMEM = v.mem_idx;  bus.rd_idx_fromWB = v.wb_idx;
        bus.alu_out_fromMEM = v.mem_data; bus.wb_data_fromWB = v.wb_data;
    endtask

    // One clock: drive, check combinational outputs, clock, check register.
    // Called right after a falling edge.
    task automatic cycle(in_t v, bit r, bit s, bit c, output res_t act);
        res_t m;
        apply(v);
        rst = r; bus.stall = s; bus.clear = c;
        #1;
        m = model(v, r, s);
        act.taken  = bus.br_taken;
        act.target = bus.br_target;
        chk("br_taken",  {31'd0, bus.br_taken}, {31'd0, m.taken});
        chk("br_target", bus.br_target, m.target);
        @(posedge clk);
        if (r)       m_reg = '{0, 0, 0, 0, 0, 0, 0, 0};
        else if (s)  m_reg = m_reg;
        else if (c)  m_reg = '{0, 0, 0, 0, 0, 0, 0, 0};
        else         m_reg = m;
        #1;
        act.alu = bus.alu_out_toMEM; act.rs2 = bus.rs2_toMEM;
        act.rd  = bus.rd_idx_toMEM;  act.f3  = bus.funct3_toMEM;
        act.mrd = bus.mem_rd_toMEM;  act.mwr = bus.mem_wr_toMEM;
        chk("alu_out_toMEM", act.alu, m_reg.alu);
        chk("rs2_toMEM",     act.rs2, m_reg.rs2);
        chk("rd_idx_toMEM",  {27'd0, act.rd}, {27'd0, m_reg.rd});
        chk("funct3_toMEM",  {29'd0, act.f3}, {29'd0, m_reg.f3});
        chk("mem_rd_toMEM",  {31'd0, act.mrd}, {31'd0, m_reg.mrd});
        chk("mem_wr_toMEM",  {31'd0, act.mwr}, {31'd0, m_reg.mwr});
        @(negedge clk);
    endtask

    vec_t tbl[$];
    logic [3:0] codes [11] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7, 4'hF};

    initial begin
        in_t  z, v, add_v, ld_v, jal_v;
        res_t a;

        z = '{default: '0};
        m_reg = '{0, 0, 0, 0, 0, 0, 0, 0};
        bus.stall = 1'b0; bus.clear = 1'b0; rst = 1'b1;
        apply(z);

        // ----- vector table -----
        v = z; v.rs1 = 5; v.rs2 = 7; v.rd_idx = 3; add_v = v;
        tbl.push_back('{"add", v, 1'b0, 32'd12, 32'd12, 32'd7, 5'd3, 1'b0});
        v = z; v.rs1 = 10; v.imm = 32'hFFFFFFFF; v.op2_ctrl = 1; v.alu_op = 4'h8; v.rd_idx = 5;
        tbl.push_back('{"addi_neg", v, 1'b0, 32'd9, 32'd9, 32'd0, 5'd5, 1'b0});
        v = z; v.rs1 = 10; v.rs2 = 3; v.alu_op = 4'h8; v.rd_idx = 5;
        tbl.push_back('{"sub", v, 1'b0, 32'd13, 32'd7, 32'd3, 5'd5, 1'b0});
        v = z; v.rs1 = 32'h80000000; v.imm = 4; v.op2_ctrl = 1; v.alu_op = 4'hD; v.rd_idx = 2;
        tbl.push_back('{"srai", v, 1'b0, 32'h80000004, 32'hF8000000, 32'd0, 5'd2, 1'b0});
        v = z; v.rs1 = 32'h80000000; v.rs2 = 32'h24; v.alu_op = 4'h5; v.rd_idx = 2;
        tbl.push_back('{"srl", v, 1'b0, 32'h80000024, 32'h08000000, 32'h24, 5'd2, 1'b0});
        v = z; v.rs1 = 32'hFFFFFFFF; v.rs2 = 1; v.alu_op = 4'h2; v.rd_idx = 4;
        tbl.push_back('{"slt", v, 1'b0, 32'd0, 32'd1, 32'd1, 5'd4, 1'b0});
        v.alu_op = 4'h3;
        tbl.push_back('{"sltu", v, 1'b0, 32'd0, 32'd0, 32'd1, 5'd4, 1'b0});
        v = z; v.rs1 = 5; v.rs2 = 7; v.alu_op = 4'hF; v.rd_idx = 4;
        tbl.push_back('{"nop", v, 1'b0, 32'd12, 32'd0, 32'd7, 5'd4, 1'b0});
        v = z; v.br_en = 1; v.funct3 = 3'd4; v.rs1 = 32'hFFFFFFFF; v.rs2 = 1;
        v.pc = 32'h100; v.imm = 32'h20; v.op1_ctrl = 1; v.op2_ctrl = 1;
        tbl.push_back('{"blt", v, 1'b1, 32'h120, 32'h120, 32'd1, 5'd0, 1'b0});
        v.funct3 = 3'd6;
        tbl.push_back('{"bltu", v, 1'b0, 32'h120, 32'h120, 32'd1, 5'd0, 1'b0});
        v = z; v.br_en = 1; v.is_jalr = 1; v.wb_sel = 1; v.rs1 = 32'h203; v.imm = 4;
        v.op2_ctrl = 1; v.pc4 = 32'h44; v.rd_idx = 1;
        tbl.push_back('{"jalr", v, 1'b1, 32'h206, 32'h44, 32'd0, 5'd1, 1'b0});
        v = z; v.br_en = 1; v.wb_sel = 1; v.op1_ctrl = 1; v.op2_ctrl = 1; v.pc = 32'h400;
        v.imm = 32'h10; v.pc4 = 32'h404; v.funct3 = 3'd2; v.rd_idx = 1; jal_v = v;
        tbl.push_back('{"jal", v, 1'b1, 32'h410, 32'h404, 32'd0, 5'd1, 1'b0});
        v = z; v.br_en = 1; v.funct3 = 3'd2; v.rs1 = 1; v.rs2 = 1; v.op1_ctrl = 1;
        v.op2_ctrl = 1; v.pc = 32'h200; v.imm = 8;
        tbl.push_back('{"br_bad_f3", v, 1'b0, 32'h208, 32'h208, 32'd1, 5'd0, 1'b0});
        v = z; v.mem_rd = 1; v.funct3 = 3'd2; v.rs1 = 32'h1000; v.imm = 8; v.op2_ctrl = 1;
        v.rd_idx = 7; ld_v = v;
        tbl.push_back('{"load", v, 1'b0, 32'h1008, 32'h1008, 32'd0, 5'd7, 1'b1});
        v = z; v.rs1_idx = 4; v.rs1 = 32'h11; v.mem_idx = 4; v.mem_data = 32'hAA;
        v.wb_idx = 4; v.wb_data = 32'hBB; v.op2_ctrl = 1; v.rd_idx = 6;
        tbl.push_back('{"fwd_prio", v, 1'b0, FWD_ON ? 32'hAA : 32'h11,
                        FWD_ON ? 32'hAA : 32'h11, 32'd0, 5'd6, 1'b0});
        v = z; v.rs1 = 1; v.rs2_idx = 9; v.rs2 = 32'h22; v.wb_idx = 9; v.wb_data = 32'hBB;
        v.mem_idx = 8; v.mem_data = 32'hCC; v.rd_idx = 6;
        tbl.push_back('{"fwd_wb_rs2", v, 1'b0, FWD_ON ? 32'hBC : 32'h23,
                        FWD_ON ? 32'hBC : 32'h23, FWD_ON ? 32'hBB : 32'h22, 5'd6, 1'b0});
        v = z; v.rs1_idx = 0; v.rs1 = 32'h33; v.mem_idx = 0; v.mem_data = 32'hAA;
        v.wb_idx = 0; v.wb_data = 32'hBB; v.op2_ctrl = 1; v.rd_idx = 6;
        tbl.push_back('{"fwd_x0", v, 1'b0, 32'h33, 32'h33, 32'd0, 5'd6, 1'b0});

        // ----- reset: a jump presented during reset must not redirect -----
        @(negedge clk);
        cycle(jal_v, 1, 0, 0, a);
        chk("rst_taken",  {31'd0, a.taken}, 32'd0);
        chk("rst_target", a.target, 32'd0);
        chk("rst_alu",    a.alu, 32'd0);
        chk("rst_rd",     {27'd0, a.rd}, 32'd0);

        foreach (tbl[i]) begin
            cycle(tbl[i].in, 0, 0, 0, a);
            chk({tbl[i].name, "_taken"},  {31'd0, a.taken}, {31'd0, tbl[i].taken});
            chk({tbl[i].name, "_target"}, a.target, tbl[i].target);
            chk({tbl[i].name, "_alu"},    a.alu, tbl[i].alu);
            chk({tbl[i].name, "_rs2"},    a.rs2, tbl[i].rs2);
            chk({tbl[i].name, "_rd"},     {27'd0, a.rd}, {27'd0, tbl[i].rd});
            chk({tbl[i].name, "_mrd"},    {31'd0, a.mrd}, {31'd0, tbl[i].mrd});
        end

        // ----- stall / clear / reset sequence -----
        cycle(ld_v, 0, 0, 0, a);
        for (int k = 0; k < 2; k++) begin
            cycle(jal_v, 0, 1, 0, a);
            chk("stall_taken", {31'd0, a.taken}, 32'd0);
            chk("stall_alu",   a.alu, 32'h1008);
            chk("stall_rd",    {27'd0, a.rd}, 32'd7);
            chk("stall_mrd",   {31'd0, a.mrd}, 32'd1);
        end
        cycle(add_v, 0, 1, 1, a);
        chk("stallclr_alu", a.alu, 32'h1008);
        chk("stallclr_rd",  {27'd0, a.rd}, 32'd7);
        cycle(add_v, 0, 0, 1, a);
        chk("clear_rd",  {27'd0, a.rd}, 32'd0);
        chk("clear_mrd", {31'd0, a.mrd}, 32'd0);
        chk("clear_mwr", {31'd0, a.mwr}, 32'd0);
        v = ld_v; v.mem_rd = 0; v.mem_wr = 1; v.rs2 = 32'h5A5A;
        cycle(v, 0, 0, 0, a);
        chk("store_mwr", {31'd0, a.mwr}, 32'd1);
        cycle(jal_v, 0, 1, 0, a);
        cycle(jal_v, 1, 1, 0, a);
        chk("rststall_taken",  {31'd0, a.taken}, 32'd0);
        chk("rststall_target", a.target, 32'd0);
        chk("rststall_alu",    a.alu, 32'd0);
        chk("rststall_rs2",    a.rs2, 32'd0);
        chk("rststall_mwr",    {31'd0, a.mwr}, 32'd0);

        // ----- random traffic vs. model -----
        for (int n = 0; n < 400; n++) begin
            v = z;
            v.alu_op   = codes[$urandom_range(0, 10)];
            v.funct3   = 3'($urandom_range(0, 7));
            v.br_en    = ($urandom_range(0, 3) == 0);
            v.is_jalr  = v.br_en && ($urandom_range(0, 3) == 0);
            v.wb_sel   = 1'($urandom_range(0, 1));
            v.op1_ctrl = 1'($urandom_range(0, 1));
            v.op2_ctrl = 1'($urandom_range(0, 1));
            v.imm      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            v.rs1      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8));
            v.rs2      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8));
            v.pc       = $urandom & 32'hFFFF_FFFC;
            v.pc4      = v.pc + 4;
            v.rs1_idx  = 5'($urandom_range(0, 7));
            v.rs2_idx  = 5'($urandom_range(0, 7));
            v.rd_idx   = 5'($urandom_range(0, 31));
            v.mem_rd   = 1'($urandom_range(0, 1));
            v.mem_wr   = !v.mem_rd && ($urandom_range(0, 1) == 1);
            v.mem_idx  = 5'($urandom_range(0, 7));
            v.wb_idx   = 5'($urandom_range(0, 7));
            v.mem_data = $urandom;
            v.wb_data  = $urandom;
            if (v.br_en && !v.is_jalr && !v.wb_sel) begin
                v.rd_idx = 0; v.mem_rd = 0; v.mem_wr = 0;
            end
            cycle(v, ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), a);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
